// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned LOAD_LAT_DEF = 1;
  localparam int unsigned CNT_W_DEF    = 16;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned LAT_W        = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic if_flush;
    logic id_noop;
  } ctrl_t;

  localparam ctrl_t CTRL_STALL    = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b0, id_noop: 1'b1};
  localparam ctrl_t CTRL_RUN      = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b0, id_noop: 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, if_flush: 1'b1, id_noop: 1'b0};
  localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, ifid_write: 1'b0, if_flush: 1'b1, id_noop: 1'b1};

  // Load in EX whose destination is a live source of the ID instruction ($0 excluded).
  function automatic logic load_use(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                    input logic uses_rs, input logic uses_rt,
                                    input logic [REG_W-1:0] wr, input logic reg_write,
                                    input logic mem_read);
    return mem_read && reg_write && (wr != '0) &&
           ((uses_rs && (rs == wr)) || (uses_rt && (rt == wr)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage hazard signals and stall/flush controls between the pipeline and the controller.
interface pipeline_hazard_ctrl_if #(parameter int unsigned CNT_W = 16);
  import pipeline_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] IFID_RS;
  logic [REG_W-1:0] IFID_RT;
  logic             IFID_UsesRS;
  logic             IFID_UsesRT;
  logic             IFID_Branch;
  logic             IFID_Jump;
  logic             BranchTaken;
  logic [REG_W-1:0] IDEX_WriteReg;
  logic             IDEX_RegWrite;
  logic             IDEX_MemRead;
  logic             Hold_Req;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFFlush;
  logic             IDNoOp;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output IFID_RS, IFID_RT, IFID_UsesRS, IFID_UsesRT, IFID_Branch, IFID_Jump,
           BranchTaken, IDEX_WriteReg, IDEX_RegWrite, IDEX_MemRead, Hold_Req,
    input  PCWrite, IFIDWrite, IFFlush, IDNoOp, StallCount, FlushCount
  );

  modport slave (
    input  IFID_RS, IFID_RT, IFID_UsesRS, IFID_UsesRT, IFID_Branch, IFID_Jump,
           BranchTaken, IDEX_WriteReg, IDEX_RegWrite, IDEX_MemRead, Hold_Req,
    output PCWrite, IFIDWrite, IFFlush, IDNoOp, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] count_q;

  // Count up on enable, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign cnt_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller beside ID: load-use stalls, external holds, redirect flushes, statistics.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_c;
  logic             lu_c;
  logic             redirect_c;

  assign lu_c = load_use(hz.IFID_RS, hz.IFID_RT, hz.IFID_UsesRS, hz.IFID_UsesRT,
                         hz.IDEX_WriteReg, hz.IDEX_RegWrite, hz.IDEX_MemRead);
  assign redirect_c = hz.IFID_Jump || (hz.IFID_Branch && hz.BranchTaken);

  // State and remaining-stall counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and same-cycle control bundle; HOLD falls through to RUN evaluation once released.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_c  = CTRL_RUN;
    case (state_q)
      STALL: begin
        ctrl_c = CTRL_STALL;
        if (hz.Hold_Req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        if (hz.Hold_Req) begin
          ctrl_c  = CTRL_STALL;
          state_d = HOLD;
        end else if (lu_c) begin
          ctrl_c = CTRL_STALL;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = LAT_INIT;
          end
        end else if (redirect_c) begin
          ctrl_c = CTRL_REDIRECT;
        end
      end
    endcase
    if (!Reset) begin
      ctrl_c = CTRL_RESET;
    end
  end

  assign hz.PCWrite   = ctrl_c.pc_write;
  assign hz.IFIDWrite = ctrl_c.ifid_write;
  assign hz.IFFlush   = ctrl_c.if_flush;
  assign hz.IDNoOp    = ctrl_c.id_noop;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .inc_i (Reset && !ctrl_c.pc_write),
    .cnt_o (hz.StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .inc_i (Reset && ctrl_c.if_flush),
    .cnt_o (hz.FlushCount)
  );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Sits beside the ID stage. Drives PC write-enable, IF/ID write-enable, IF/ID flush and the ID/EX bubble insert.
- Sequences multi-cycle load-use stalls and external hold requests with an FSM.
- Keeps saturating stall and flush statistics counters.

Parameters:
- LOAD_LAT, 1: number of stall cycles inserted per load-use hazard (1..7).
- CNT_W, 16: width of the statistics counters.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IFID_RS  in  5  rs field of the instruction in ID.
- IFID_RT  in  5  rt field of the instruction in ID.
- IFID_UsesRS  in  1  ID instruction reads rs.
- IFID_UsesRT  in  1  ID instruction reads rt.
- IFID_Branch  in  1  ID instruction is a conditional branch.
- IFID_Jump  in  1  ID instruction is a jump.
- BranchTaken  in  1  branch compare result from ID.
- IDEX_WriteReg  in  5  destination register of the EX instruction.
- IDEX_RegWrite  in  1  EX instruction writes a register.
- IDEX_MemRead  in  1  EX instruction is a load.
- Hold_Req  in  1  external freeze request (e.g. multi-cycle unit busy).
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID buffer load enable.
- IFFlush  out  1  replace the IF/ID contents with a nop on the next edge.
- IDNoOp  out  1  zero the ID/EX control signals (bubble).
- StallCount  out  CNT_W  stalled cycles since reset, saturating.
- FlushCount  out  CNT_W  flushes since reset, saturating.

Behaviour:
- Reset low (asynchronous):
  - State goes to RUN; the internal stall counter and both statistics counters clear to 0.
  - While Reset is low, outputs are forced to PCWrite=0, IFIDWrite=0, IDNoOp=1, IFFlush=1.
- Hazard detect (combinational), LU =
  - IDEX_MemRead & IDEX_RegWrite & (IDEX_WriteReg != 0), and
  - ((IFID_UsesRS & IFID_RS == IDEX_WriteReg) | (IFID_UsesRT & IFID_RT == IDEX_WriteReg)).
- No stall is generated for:
  - ALU results in EX;
  - loads already in MEM (covered by forwarding);
  - branch operands from either of the above (forwarded into the ID compare).
- Control outputs are Mealy (same-cycle) functions of state and inputs. STALL bundle = PCWrite=0, IFIDWrite=0, IDNoOp=1, IFFlush=0.
- States: RUN, STALL, HOLD.
- RUN, priority Hold_Req > LU > redirect:
  - Hold_Req=1: STALL bundle; next state HOLD.
  - LU=1: STALL bundle. If LOAD_LAT=1, stay in RUN. Otherwise go to STALL with cnt=LOAD_LAT-1.
  - Redirect, i.e. IFID_Jump | (IFID_Branch & BranchTaken): PCWrite=1, IFIDWrite=1, IFFlush=1, IDNoOp=0.
  - Otherwise: PCWrite=1, IFIDWrite=1, IFFlush=0, IDNoOp=0.
- STALL:
  - STALL bundle every cycle; cnt decrements each cycle.
  - When cnt==1, next state RUN.
  - Hold_Req in STALL has priority: go to HOLD, discarding the remaining cnt.
- HOLD:
  - STALL bundle while Hold_Req=1.
  - When Hold_Req=0, next state RUN, and RUN evaluates hazards that same cycle.
- Redirects are ignored in any stalled cycle (operands not valid); IFFlush is never asserted together with IDNoOp.
- StallCount increments on every cycle in which PCWrite=0 (Reset high) and saturates at all-ones.
- FlushCount increments on every cycle with IFFlush=1 (Reset high) and saturates at all-ones.
- Register $0 never creates a hazard.
- Reset mid-stall aborts the sequence immediately; the first cycle after release is RUN.

Decomposition:
- Shared package holds:
  - state encoding constants RUN=2'd0, STALL=2'd1, HOLD=2'd2;
  - the STALL control-bundle constant;
  - defaults for LOAD_LAT and CNT_W.
- One natural sub-module: sat_counter (CNT_W-bit, async active-low clear, increment enable, saturate at max), instantiated twice.

Test Plan:
- Reset low 3 cycles, then high with no hazards → during reset PCWrite=0, IFFlush=1, IDNoOp=1; after release PCWrite=1, IFIDWrite=1, counters 0.
- lw to $5 in EX, add in ID reading rs=$5, LOAD_LAT=1 → exactly 1 cycle with PCWrite=0 and IDNoOp=1, then RUN; StallCount=1.
- Same hazard with LOAD_LAT=3 → 3 consecutive stall cycles, StallCount=3; the rt-only match case behaves identically; a match on $0 gives no stall.
- beq in ID with BranchTaken=1 and no hazard → IFFlush=1 for 1 cycle, FlushCount=1. With a simultaneous LU, no flush and 1 stall cycle; the flush follows on the next cycle.
- Hold_Req high 4 cycles starting in cycle 2 of a LOAD_LAT=3 stall → HOLD for 4 cycles, then RUN; StallCount=5.
- Force 2^CNT_W+2 stall cycles (CNT_W=4 build) → StallCount holds at 15.
